// File: rtl/pwm_peripheral_if.sv
// Configuration / output bundle between the SPI register bank and the PWM output stage.
// master drives the register bytes and enable; slave (pwm_peripheral) drives the chip outputs.
interface pwm_peripheral_if;
  logic        ena;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output ena, en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  ena, en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-bit registered output stage: each bit forced low, static high, or the shared 8-bit PWM.
// Macro PWM_DUTY_SHADOW_EN: when defined, the duty is latched only at the period wrap.
module pwm_peripheral #(
  parameter int PRESCALE   = 13,
  parameter int PRESCALE_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  pwm_peripheral_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [7:0]            CNT_LAST = 8'd254;

  logic [PRESCALE_W-1:0] pre_cnt_p0;
  logic [7:0]            pwm_cnt_p0;
  logic [7:0]            duty_act;
  logic                  tick;
  logic                  wrap;
  logic                  pwm_sig;
  logic [15:0]           en_out;
  logic [15:0]           en_pwm;
  logic [15:0]           out_p1;
  logic                  period_start_p1;

  function automatic logic [15:0] out_sel(input logic [15:0] eo,
                                          input logic [15:0] ep,
                                          input logic        sig);
    return eo & (~ep | {16{sig}});
  endfunction

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  assign tick = bus.ena && (pre_cnt_p0 == PRE_LAST);
  assign wrap = tick && (pwm_cnt_p0 == CNT_LAST);

  // Stage p0: prescaler and PWM counter, both frozen while ena is low
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_p0 <= '0;
    end else if (bus.ena) begin
      pre_cnt_p0 <= tick ? '0 : pre_cnt_p0 + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_p0 <= '0;
    end else if (tick) begin
      pwm_cnt_p0 <= wrap ? '0 : pwm_cnt_p0 + 8'd1;
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_act <= '0;
    end else if (wrap) begin
      duty_act <= bus.pwm_duty_cycle;
    end
  end
`else
  assign duty_act = bus.pwm_duty_cycle;
`endif

  // pwm_cnt tops out at 254, so duty 0xFF keeps the compare true all period
  assign pwm_sig = (pwm_cnt_p0 < duty_act);

  // Stage p1: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1          <= '0;
      period_start_p1 <= 1'b0;
    end else if (bus.ena) begin
      out_p1          <= out_sel(en_out, en_pwm, pwm_sig);
      period_start_p1 <= wrap;
    end else begin
      out_p1          <= '0;
      period_start_p1 <= 1'b0;
    end
  end

  assign bus.out          = out_p1;
  assign bus.period_start = period_start_p1;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: directed waveform measurements plus randomized traffic checked
// cycle by cycle against a phase-based reference model.
module tb_pwm_peripheral;

  localparam int PRESCALE = 13;
  localparam int PER      = PRESCALE * 255;

`ifdef PWM_DUTY_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_peripheral_if bus ();

  pwm_peripheral #(.PRESCALE(PRESCALE), .PRESCALE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_ph;
  logic [7:0]  m_duty;
  logic [15:0] m_out;
  logic        m_ps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    bus.en_reg_out_7_0  = eo[7:0];
    bus.en_reg_out_15_8 = eo[15:8];
    bus.en_reg_pwm_7_0  = ep[7:0];
    bus.en_reg_pwm_15_8 = ep[15:8];
  endtask

  // One clock: advance the model from the inputs present at the edge, then compare
  task automatic step();
    logic [15:0] eo, ep;
    logic [7:0]  d, duty_eff;
    logic        e, r, pwm;
    int          cnt;
    eo = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    ep = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    d  = bus.pwm_duty_cycle;
    e  = bus.ena;
    r  = rst;
    @(posedge clk);
    if (r) begin
      m_ph = 0; m_duty = 8'h00; m_out = 16'h0000; m_ps = 1'b0;
    end else if (!e) begin
      m_out = 16'h0000; m_ps = 1'b0;
    end else begin
      cnt      = m_ph / PRESCALE;
      duty_eff = SHADOW ? m_duty : d;
      pwm      = (cnt < int'(duty_eff));
      for (int i = 0; i < 16; i++)
        m_out[i] = eo[i] ? (ep[i] ? pwm : 1'b1) : 1'b0;
      m_ps = (m_ph == PER - 1);
      if (m_ph == PER - 1) begin
        m_ph = 0;
        if (SHADOW) m_duty = d;
      end else begin
        m_ph++;
      end
    end
    #1;
    chk("out", 32'(bus.out), 32'(m_out));
    chk("period_start", 32'(bus.period_start), 32'(m_ps));
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.period_start && n < PER + 200);
    chk("ps_timeout", 32'(bus.period_start), 32'd1);
  endtask

  // Runs from one period_start to the next, counting high samples of out[0]
  task automatic run_window(input int change_at, input logic [7:0] nd,
                            output int highs, output int len);
    highs = 0;
    len   = 0;
    do begin
      step();
      len++;
      if (bus.out[0]) highs++;
      if (len == change_at) bus.pwm_duty_cycle = nd;
    end while (!bus.period_start && len < PER + 200);
    chk("window_timeout", 32'(bus.period_start), 32'd1);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l, n;
    logic [15:0] odd;
    m_ph = 0; m_duty = 8'h00; m_out = 16'h0000; m_ps = 1'b0;
    rst = 1'b1;
    bus.ena = 1'b1;
    bus.pwm_duty_cycle = 8'h00;
    set_en(16'h00FF, 16'h0000);

    // Reset, static high, force low
    step();
    chk("rst_out_c1", 32'(bus.out), 32'h0000);
    step();
    chk("rst_out_c2", 32'(bus.out), 32'h0000);
    chk("rst_ps", 32'(bus.period_start), 32'd0);
    rst = 1'b0;
    step();
    chk("static_high", 32'(bus.out), 32'h00FF);
    set_en(16'h0000, 16'h0000);
    step();
    chk("force_low", 32'(bus.out), 32'h0000);

    // 50 % duty
    set_en(16'h0001, 16'h0001);
    bus.pwm_duty_cycle = 8'h80;
    wait_ps(n);
    run_window(-1, 8'h00, h, l);
    chk("half_high", 32'(h), 32'd1664);
    chk("half_low", 32'(l - h), 32'd1651);
    chk("half_period", 32'(l), 32'd3315);

    // Duty extremes
    bus.pwm_duty_cycle = 8'h00;
    wait_ps(n);
    run_window(-1, 8'h00, h, l);
    chk("zero_high_p1", 32'(h), 32'd0);
    run_window(-1, 8'h00, h, l);
    chk("zero_high_p2", 32'(h), 32'd0);
    bus.pwm_duty_cycle = 8'hFF;
    wait_ps(n);
    run_window(-1, 8'h00, h, l);
    chk("full_high", 32'(h), 32'd3315);

    // Duty change at pwm_cnt == 100 (1300 clocks into the period)
    bus.pwm_duty_cycle = 8'h40;
    wait_ps(n);
    run_window(1300, 8'hC0, h, l);
    chk("mid_cur_high", 32'(h), SHADOW ? 32'd832 : 32'd2028);
    run_window(-1, 8'h00, h, l);
    chk("mid_next_high", 32'(h), 32'd2496);

    // ena gating stretches the period
    wait_ps(n);
    repeat (1000) step();
    bus.ena = 1'b0;
    repeat (50) step();
    chk("ena_gap_out", 32'(bus.out), 32'h0000);
    bus.ena = 1'b1;
    wait_ps(n);
    chk("ena_stretch", 32'(1000 + 50 + n), 32'd3365);

    // Mixed bits
    set_en(16'hFFFF, 16'hAAAA);
    bus.pwm_duty_cycle = 8'h80;
    wait_ps(n);
    repeat (100) step();
    odd = bus.out & 16'hAAAA;
    chk("mixed_even_hi", 32'(bus.out & 16'h5555), 32'h5555);
    chk("mixed_odd_hi", 32'(odd), 32'hAAAA);
    repeat (2000) step();
    odd = bus.out & 16'hAAAA;
    chk("mixed_even_lo", 32'(bus.out & 16'h5555), 32'h5555);
    chk("mixed_odd_lo", 32'(odd), 32'h0000);

    // Randomized traffic including mid-period reset and ena drops
    for (int k = 0; k < 12000; k++) begin
      if ($urandom_range(0, 99) < 3) set_en(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 99) < 2) bus.pwm_duty_cycle = 8'($urandom);
      bus.ena = ($urandom_range(0, 49) != 0);
      rst     = ($urandom_range(0, 1999) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
